// File: rtl/id_iq.sv
// In-order issue queue with register scoreboard between decode lanes and the EX pipeline register.
// Up to IW uops enqueued and issued per cycle; issue stops at the first hazard.
module id_iq #(
    parameter int unsigned CONFIG_P_ISSUE_WIDTH = 1,
    parameter int unsigned CONFIG_P_IQ_DEPTH    = 3,
    parameter int unsigned CONFIG_UOP_W         = 64,
    parameter int unsigned CONFIG_NUM_WB        = 2,
    parameter int unsigned NCPU_REG_AW          = 5,
    localparam int unsigned IW  = 1 << CONFIG_P_ISSUE_WIDTH,
    localparam int unsigned UW  = CONFIG_UOP_W,
    localparam int unsigned AW  = NCPU_REG_AW,
    localparam int unsigned NWB = CONFIG_NUM_WB,
    localparam int unsigned PW  = CONFIG_P_IQ_DEPTH + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stall,
    input  logic [IW-1:0]      enq_valid,
    input  logic [IW*UW-1:0]   enq_uop,
    input  logic [IW-1:0]      enq_rf_we,
    input  logic [IW-1:0]      enq_long,
    input  logic [IW-1:0]      enq_single,
    input  logic [IW-1:0]      enq_rs1_re,
    input  logic [IW-1:0]      enq_rs2_re,
    input  logic [IW*AW-1:0]   enq_rf_waddr,
    input  logic [IW*AW-1:0]   enq_rs1_addr,
    input  logic [IW*AW-1:0]   enq_rs2_addr,
    output logic               enq_ready,
    output logic [IW-1:0]      iss_valid,
    output logic [IW*UW-1:0]   iss_uop,
    output logic [IW-1:0]      iss_rf_we,
    output logic [IW*AW-1:0]   iss_rf_waddr,
    input  logic [NWB-1:0]     wb_valid,
    input  logic [NWB*AW-1:0]  wb_addr,
    output logic [PW-1:0]      iq_cnt
);

    localparam int unsigned D    = 1 << CONFIG_P_IQ_DEPTH;
    localparam int unsigned PI   = CONFIG_P_IQ_DEPTH;
    localparam int unsigned NREG = 1 << AW;

    typedef struct packed {
        logic [UW-1:0] uop;
        logic          rf_we;
        logic          lng;
        logic          single;
        logic          rs1_re;
        logic          rs2_re;
        logic [AW-1:0] waddr;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
    } entry_t;

    entry_t          mem   [D];
    entry_t          enq_e [IW];
    entry_t          slot  [IW];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   cnt_next;
    logic [PW-1:0]   enq_n;
    logic [PW-1:0]   iss_n;
    logic            enq_fire;
    logic [IW-1:0]   issue_vec;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] sb_eff;

    // Unpack per-lane enqueue buses into entries
    always_comb begin
        for (int i = 0; i < IW; i++) begin
            enq_e[i].uop    = enq_uop[i*UW +: UW];
            enq_e[i].rf_we  = enq_rf_we[i];
            enq_e[i].lng    = enq_long[i];
            enq_e[i].single = enq_single[i];
            enq_e[i].rs1_re = enq_rs1_re[i];
            enq_e[i].rs2_re = enq_rs2_re[i];
            enq_e[i].waddr  = enq_rf_waddr[i*AW +: AW];
            enq_e[i].rs1    = enq_rs1_addr[i*AW +: AW];
            enq_e[i].rs2    = enq_rs2_addr[i*AW +: AW];
        end
    end

    always_comb begin
        enq_n = '0;
        for (int i = 0; i < IW; i++) begin
            enq_n = enq_n + PW'(enq_valid[i]);
        end
    end

    assign enq_fire = enq_ready & (|enq_valid) & ~flush;

    // Candidate window starting at head
    always_comb begin
        for (int k = 0; k < IW; k++) begin
            slot[k] = mem[head[PI-1:0] + PI'(k)];
        end
    end

    // Same-cycle writebacks bypass the scoreboard
    always_comb begin
        clr_vec = '0;
        for (int p = 0; p < NWB; p++) begin
            if (wb_valid[p]) begin
                clr_vec[wb_addr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    assign sb_eff = sb & ~clr_vec;

    // Issue selection: in-order, cut at the first slot with a hazard
    always_comb begin
        logic go;
        logic haz;
        issue_vec = '0;
        set_vec   = '0;
        iss_n     = '0;
        go        = ~stall & ~flush;
        for (int k = 0; k < IW; k++) begin
            haz = 1'b0;
            for (int j = 0; j < IW; j++) begin
                if (j < k && slot[j].rf_we && slot[j].waddr != '0) begin
                    if (slot[k].rs1_re && slot[k].rs1 == slot[j].waddr) haz = 1'b1;
                    if (slot[k].rs2_re && slot[k].rs2 == slot[j].waddr) haz = 1'b1;
                    if (slot[k].rf_we && slot[k].waddr == slot[j].waddr) haz = 1'b1;
                end
            end
            if (slot[k].rs1_re && slot[k].rs1 != '0 && sb_eff[slot[k].rs1]) haz = 1'b1;
            if (slot[k].rs2_re && slot[k].rs2 != '0 && sb_eff[slot[k].rs2]) haz = 1'b1;
            if (slot[k].rf_we && slot[k].waddr != '0 && sb_eff[slot[k].waddr]) haz = 1'b1;
            if (k > 0 && slot[k].single) haz = 1'b1;
            go = go & (PW'(k) < iq_cnt) & ~haz;
            issue_vec[k] = go;
            if (go) begin
                iss_n = iss_n + PW'(1);
                if (slot[k].rf_we && slot[k].lng && slot[k].waddr != '0) begin
                    set_vec[slot[k].waddr] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (flush) begin
            cnt_next = '0;
        end else begin
            cnt_next = iq_cnt + (enq_fire ? enq_n : PW'(0)) - iss_n;
        end
    end

    // Entry storage; payload needs no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < IW; i++) begin
            if (enq_fire && enq_valid[i]) begin
                mem[tail[PI-1:0] + PI'(i)] <= enq_e[i];
            end
        end
    end

    // Pointers, occupancy, scoreboard and issue registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            iq_cnt       <= '0;
            sb           <= '0;
            enq_ready    <= 1'b1;
            iss_valid    <= '0;
            iss_uop      <= '0;
            iss_rf_we    <= '0;
            iss_rf_waddr <= '0;
        end else begin
            sb        <= sb_eff | set_vec;
            iq_cnt    <= cnt_next;
            enq_ready <= (PW'(D) - cnt_next) >= PW'(IW);
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                iss_valid <= '0;
            end else begin
                head <= head + iss_n;
                if (enq_fire) begin
                    tail <= tail + enq_n;
                end
                if (!stall) begin
                    iss_valid <= issue_vec;
                    for (int k = 0; k < IW; k++) begin
                        iss_uop[k*UW +: UW]      <= slot[k].uop;
                        iss_rf_we[k]             <= issue_vec[k] & slot[k].rf_we;
                        iss_rf_waddr[k*AW +: AW] <= slot[k].waddr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_id_iq.sv
// Bench for id_iq (IW=2, D=8): vector table, directed multi-cycle sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_id_iq;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         stall;
    logic [1:0]   enq_valid;
    logic [127:0] enq_uop;
    logic [1:0]   enq_rf_we;
    logic [1:0]   enq_long;
    logic [1:0]   enq_single;
    logic [1:0]   enq_rs1_re;
    logic [1:0]   enq_rs2_re;
    logic [9:0]   enq_rf_waddr;
    logic [9:0]   enq_rs1_addr;
    logic [9:0]   enq_rs2_addr;
    logic         enq_ready;
    logic [1:0]   iss_valid;
    logic [127:0] iss_uop;
    logic [1:0]   iss_rf_we;
    logic [9:0]   iss_rf_waddr;
    logic [1:0]   wb_valid;
    logic [9:0]   wb_addr;
    logic [3:0]   iq_cnt;

    int n_cmp;
    int n_fail;

    id_iq dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall       (stall),
        .enq_valid   (enq_valid),
        .enq_uop     (enq_uop),
        .enq_rf_we   (enq_rf_we),
        .enq_long    (enq_long),
        .enq_single  (enq_single),
        .enq_rs1_re  (enq_rs1_re),
        .enq_rs2_re  (enq_rs2_re),
        .enq_rf_waddr(enq_rf_waddr),
        .enq_rs1_addr(enq_rs1_addr),
        .enq_rs2_addr(enq_rs2_addr),
        .enq_ready   (enq_ready),
        .iss_valid   (iss_valid),
        .iss_uop     (iss_uop),
        .iss_rf_we   (iss_rf_we),
        .iss_rf_waddr(iss_rf_waddr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .iq_cnt      (iq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] uid(input int id);
        return {32'hA5A5_0000, 32'(id)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        enq_valid = '0; enq_uop = '0; enq_rf_we = '0; enq_long = '0; enq_single = '0;
        enq_rs1_re = '0; enq_rs2_re = '0; enq_rf_waddr = '0; enq_rs1_addr = '0; enq_rs2_addr = '0;
        wb_valid = '0; wb_addr = '0;
    endtask

    task automatic set_lane(input int l, input int id, input logic we, input logic lng,
                            input logic sgl, input logic [4:0] wd, input logic [4:0] s1,
                            input logic [4:0] s2);
        enq_valid[l]         = 1'b1;
        enq_uop[l*64 +: 64]  = uid(id);
        enq_rf_we[l]         = we;
        enq_long[l]          = lng;
        enq_single[l]        = sgl;
        enq_rs1_re[l]        = 1'b1;
        enq_rs2_re[l]        = 1'b1;
        enq_rf_waddr[l*5 +: 5] = wd;
        enq_rs1_addr[l*5 +: 5] = s1;
        enq_rs2_addr[l*5 +: 5] = s2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the currently driven inputs, then check the visible state
    task automatic cyc(input string nm, input logic [1:0] eiv, input logic [3:0] ecnt, input logic erdy);
        tick();
        chk({nm, ".iss_valid"}, 64'(iss_valid), 64'(eiv));
        chk({nm, ".iq_cnt"},    64'(iq_cnt),    64'(ecnt));
        chk({nm, ".enq_ready"}, 64'(enq_ready), 64'(erdy));
        idle();
    endtask

    typedef struct {
        logic       rstn;
        logic [1:0] ev, we, lng, sgl;
        logic [4:0] wd0, s0, wd1, s1;
        logic [1:0] eiv;
        logic [3:0] ecnt;
        logic       erdy;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic [1:0] ev, input logic [1:0] we,
                                input logic [1:0] lng, input logic [1:0] sgl,
                                input logic [4:0] wd0, input logic [4:0] s0,
                                input logic [4:0] wd1, input logic [4:0] s1,
                                input logic [1:0] eiv, input logic [3:0] ecnt, input logic erdy);
        vec_t v;
        v.rstn = rstn; v.ev = ev; v.we = we; v.lng = lng; v.sgl = sgl;
        v.wd0 = wd0; v.s0 = s0; v.wd1 = wd1; v.s1 = s1;
        v.eiv = eiv; v.ecnt = ecnt; v.erdy = erdy;
        return v;
    endfunction

    // Reference model: ordered list of waiting uops plus a set of busy registers
    typedef struct packed {
        logic [63:0] uop;
        logic        we, lng, sgl, r1e, r2e;
        logic [4:0]  wd, s1, s2;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy;
    logic [1:0]  m_iv;
    logic [63:0] m_uop [2];
    logic [4:0]  m_wd  [2];
    logic        m_we  [2];
    logic        m_rdy;

    function automatic bit blocked(input logic [4:0] r, input logic [31:0] written,
                                   input logic [31:0] clr);
        return (r != 5'd0) && (written[r] || (m_busy[r] && !clr[r]));
    endfunction

    task automatic model_step();
        logic [31:0] clr, setv, written;
        int   n;
        bit   ok;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_busy = '0; m_iv = '0; m_rdy = 1'b1;
            return;
        end
        clr = '0;
        for (int p = 0; p < 2; p++) if (wb_valid[p]) clr[wb_addr[p*5 +: 5]] = 1'b1;
        setv = '0; written = '0; n = 0;
        if (!stall && !flush) begin
            for (int k = 0; k < 2; k++) begin
                if (k >= mq.size()) break;
                e  = mq[k];
                ok = !(k > 0 && e.sgl);
                if (e.r1e && blocked(e.s1, written, clr)) ok = 0;
                if (e.r2e && blocked(e.s2, written, clr)) ok = 0;
                if (e.we  && blocked(e.wd, written, clr)) ok = 0;
                if (!ok) break;
                if (e.we && e.wd != 5'd0) begin
                    written[e.wd] = 1'b1;
                    if (e.lng) setv[e.wd] = 1'b1;
                end
                n++;
            end
        end
        m_busy = (m_busy & ~clr) | setv;
        if (flush) begin
            mq.delete();
            m_iv = '0;
        end else begin
            if (!stall) begin
                m_iv = '0;
                for (int k = 0; k < n; k++) begin
                    m_iv[k]  = 1'b1;
                    m_uop[k] = mq[k].uop;
                    m_wd[k]  = mq[k].wd;
                    m_we[k]  = mq[k].we;
                end
            end
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            if (m_rdy && enq_valid != 2'b00) begin
                for (int l = 0; l < 2; l++) begin
                    if (enq_valid[l]) begin
                        e.uop = enq_uop[l*64 +: 64];
                        e.we  = enq_rf_we[l];  e.lng = enq_long[l]; e.sgl = enq_single[l];
                        e.r1e = enq_rs1_re[l]; e.r2e = enq_rs2_re[l];
                        e.wd  = enq_rf_waddr[l*5 +: 5];
                        e.s1  = enq_rs1_addr[l*5 +: 5];
                        e.s2  = enq_rs2_addr[l*5 +: 5];
                        mq.push_back(e);
                    end
                end
            end
        end
        m_rdy = (8 - mq.size()) >= 2;
    endtask

    vec_t vt [19];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle();

        //          rstn ev     we     lng    sgl    wd0    s0     wd1    s1     eiv    cnt   rdy
        vt[0]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b00, 4'd0, 1'b1);
        vt[1]  = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 5'd1,  5'd2, 5'd4,  5'd5, 2'b00, 4'd2, 1'b1);
        vt[2]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b11, 4'd0, 1'b1);
        vt[3]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b00, 4'd0, 1'b1);
        vt[4]  = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 5'd3,  5'd1, 5'd4,  5'd3, 2'b00, 4'd2, 1'b1);
        vt[5]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd1, 1'b1);
        vt[6]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd0, 1'b1);
        vt[7]  = mk(1, 2'b11, 2'b11, 2'b00, 2'b10, 5'd7,  5'd1, 5'd8,  5'd2, 2'b00, 4'd2, 1'b1);
        vt[8]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd1, 1'b1);
        vt[9]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd0, 1'b1);
        vt[10] = mk(1, 2'b11, 2'b11, 2'b11, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b00, 4'd2, 1'b1);
        vt[11] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b11, 4'd0, 1'b1);
        vt[12] = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 5'd9,  5'd0, 5'd10, 5'd0, 2'b00, 4'd2, 1'b1);
        vt[13] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b11, 4'd0, 1'b1);
        vt[14] = mk(1, 2'b11, 2'b11, 2'b00, 2'b00, 5'd11, 5'd1, 5'd11, 5'd2, 2'b00, 4'd2, 1'b1);
        vt[15] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd1, 1'b1);
        vt[16] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd0, 1'b1);
        vt[17] = mk(1, 2'b01, 2'b01, 2'b00, 2'b01, 5'd12, 5'd1, 5'd0,  5'd0, 2'b00, 4'd1, 1'b1);
        vt[18] = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0,  5'd0, 5'd0,  5'd0, 2'b01, 4'd0, 1'b1);

        for (int i = 0; i < 19; i++) begin
            idle();
            rst = vt[i].rstn;
            if (vt[i].ev[0]) set_lane(0, i*2,   vt[i].we[0], vt[i].lng[0], vt[i].sgl[0], vt[i].wd0, vt[i].s0, 5'd0);
            if (vt[i].ev[1]) set_lane(1, i*2+1, vt[i].we[1], vt[i].lng[1], vt[i].sgl[1], vt[i].wd1, vt[i].s1, 5'd0);
            cyc($sformatf("vec%0d", i), vt[i].eiv, vt[i].ecnt, vt[i].erdy);
        end

        // Long load r5, dependent r6 waits for writeback
        set_lane(0, 50, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd0);
        set_lane(1, 51, 1'b1, 1'b0, 1'b0, 5'd6, 5'd5, 5'd0);
        cyc("ld_enq", 2'b00, 4'd2, 1'b1);
        cyc("ld_iss", 2'b01, 4'd1, 1'b1);
        chk("ld_iss.waddr", 64'(iss_rf_waddr[4:0]), 64'd5);
        chk("ld_iss.uop", iss_uop[63:0], uid(50));
        for (int w = 0; w < 5; w++) cyc($sformatf("ld_wait%0d", w), 2'b00, 4'd1, 1'b1);
        wb_valid[0] = 1'b1; wb_addr[4:0] = 5'd5;
        cyc("ld_wb", 2'b01, 4'd0, 1'b1);
        chk("ld_wb.uop", iss_uop[63:0], uid(51));
        cyc("ld_done", 2'b00, 4'd0, 1'b1);

        // Fill to capacity under stall, overflow ignored, drain across the wrap
        for (int b = 0; b < 4; b++) begin
            stall = 1'b1;
            set_lane(0, 100 + 2*b, 1'b1, 1'b0, 1'b0,        5'(12 + 2*b), 5'd0, 5'd0);
            set_lane(1, 101 + 2*b, 1'b1, 1'b0, (b == 0),    5'(13 + 2*b), 5'd0, 5'd0);
            cyc($sformatf("fill%0d", b), 2'b00, 4'(2*b + 2), (b < 3));
        end
        stall = 1'b1;
        set_lane(0, 200, 1'b1, 1'b0, 1'b0, 5'd30, 5'd0, 5'd0);
        set_lane(1, 201, 1'b1, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0);
        cyc("fill_over", 2'b00, 4'd8, 1'b0);
        set_lane(0, 202, 1'b1, 1'b0, 1'b0, 5'd30, 5'd0, 5'd0);
        set_lane(1, 203, 1'b1, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0);
        cyc("drain0", 2'b01, 4'd7, 1'b0);
        chk("drain0.uop0", iss_uop[63:0], uid(100));
        set_lane(0, 204, 1'b1, 1'b0, 1'b0, 5'd30, 5'd0, 5'd0);
        set_lane(1, 205, 1'b1, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0);
        cyc("drain1", 2'b11, 4'd5, 1'b1);
        chk("drain1.uop0", iss_uop[63:0],   uid(101));
        chk("drain1.uop1", iss_uop[127:64], uid(102));
        set_lane(0, 108, 1'b1, 1'b0, 1'b0, 5'd22, 5'd0, 5'd0);
        set_lane(1, 109, 1'b1, 1'b0, 1'b0, 5'd23, 5'd0, 5'd0);
        cyc("drain2", 2'b11, 4'd5, 1'b1);
        chk("drain2.uop0", iss_uop[63:0],   uid(103));
        chk("drain2.uop1", iss_uop[127:64], uid(104));
        cyc("drain3", 2'b11, 4'd3, 1'b1);
        chk("drain3.uop1", iss_uop[127:64], uid(106));
        cyc("drain4", 2'b11, 4'd1, 1'b1);
        chk("drain4.uop0", iss_uop[63:0],   uid(107));
        chk("drain4.uop1", iss_uop[127:64], uid(108));
        cyc("drain5", 2'b01, 4'd0, 1'b1);
        chk("drain5.uop0", iss_uop[63:0],   uid(109));

        // Flush while stalled keeps the scoreboard
        set_lane(0, 300, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0);
        cyc("fl_ld", 2'b00, 4'd1, 1'b1);
        cyc("fl_iss", 2'b01, 4'd0, 1'b1);
        stall = 1'b1;
        set_lane(0, 301, 1'b1, 1'b0, 1'b0, 5'd24, 5'd5, 5'd0);
        set_lane(1, 302, 1'b1, 1'b0, 1'b0, 5'd25, 5'd0, 5'd0);
        cyc("fl_q2", 2'b01, 4'd2, 1'b1);
        stall = 1'b1;
        set_lane(0, 303, 1'b1, 1'b0, 1'b0, 5'd26, 5'd0, 5'd0);
        set_lane(1, 304, 1'b1, 1'b0, 1'b0, 5'd27, 5'd0, 5'd0);
        cyc("fl_q4", 2'b01, 4'd4, 1'b1);
        stall = 1'b1;
        set_lane(0, 305, 1'b1, 1'b0, 1'b0, 5'd28, 5'd0, 5'd0);
        cyc("fl_q5", 2'b01, 4'd5, 1'b1);
        stall = 1'b1; flush = 1'b1;
        set_lane(0, 306, 1'b1, 1'b0, 1'b0, 5'd29, 5'd0, 5'd0);
        set_lane(1, 307, 1'b1, 1'b0, 1'b0, 5'd30, 5'd0, 5'd0);
        cyc("fl_flush", 2'b00, 4'd0, 1'b1);
        set_lane(0, 308, 1'b1, 1'b0, 1'b0, 5'd29, 5'd5, 5'd0);
        cyc("fl_dep", 2'b00, 4'd1, 1'b1);
        cyc("fl_busy0", 2'b00, 4'd1, 1'b1);
        cyc("fl_busy1", 2'b00, 4'd1, 1'b1);
        wb_valid[1] = 1'b1; wb_addr[9:5] = 5'd5;
        cyc("fl_wb", 2'b01, 4'd0, 1'b1);
        chk("fl_wb.uop", iss_uop[63:0], uid(308));

        // Set and clear of one register in the same cycle leaves it busy
        set_lane(0, 310, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0);
        cyc("sw_enq", 2'b00, 4'd1, 1'b1);
        wb_valid[0] = 1'b1; wb_addr[4:0] = 5'd7;
        cyc("sw_iss", 2'b01, 4'd0, 1'b1);
        set_lane(0, 311, 1'b1, 1'b0, 1'b0, 5'd8, 5'd7, 5'd0);
        cyc("sw_dep", 2'b00, 4'd1, 1'b1);
        cyc("sw_hold", 2'b00, 4'd1, 1'b1);
        wb_valid[0] = 1'b1; wb_addr[4:0] = 5'd7;
        cyc("sw_wb", 2'b01, 4'd0, 1'b1);
        chk("sw_wb.uop", iss_uop[63:0], uid(311));

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            int r;
            idle();
            rst   = (c == 0) ? 1'b0 : 1'($urandom_range(0, 99) != 0);
            flush = 1'($urandom_range(0, 39) == 0);
            stall = 1'($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 3);
            for (int l = 0; l < ((r == 0) ? 0 : (r == 1) ? 1 : 2); l++) begin
                set_lane(l, 1000 + 2*c + l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 4) == 0), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                enq_rs1_re[l] = 1'($urandom_range(0, 1));
                enq_rs2_re[l] = 1'($urandom_range(0, 1));
            end
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    wb_valid[p] = 1'b1;
                    wb_addr[p*5 +: 5] = 5'($urandom_range(0, 7));
                end
            end
            model_step();
            tick();
            chk($sformatf("rnd%0d.iss_valid", c), 64'(iss_valid), 64'(m_iv));
            chk($sformatf("rnd%0d.iq_cnt", c),    64'(iq_cnt),    64'(mq.size()));
            chk($sformatf("rnd%0d.enq_ready", c), 64'(enq_ready), 64'(m_rdy));
            for (int l = 0; l < 2; l++) begin
                if (m_iv[l]) begin
                    chk($sformatf("rnd%0d.uop%0d", c, l),   iss_uop[l*64 +: 64],          m_uop[l]);
                    chk($sformatf("rnd%0d.waddr%0d", c, l), 64'(iss_rf_waddr[l*5 +: 5]), 64'(m_wd[l]));
                    chk($sformatf("rnd%0d.we%0d", c, l),    64'(iss_rf_we[l]),           64'(m_we[l]));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
